// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared limits and defaults for the parameterised sequence detector
package seq_pkg;
    localparam int PAT_LEN_MIN     = 2;
    localparam int PAT_LEN_MAX     = 16;
    localparam int CNT_W_MIN       = 2;
    localparam int CNT_W_MAX       = 16;
    localparam int DEFAULT_PAT_LEN = 4;
    localparam int DEFAULT_CNT_W   = 8;
    localparam logic [DEFAULT_PAT_LEN-1:0] DEFAULT_PATTERN = 4'b1100;

    function automatic int match_width(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction
endpackage

// File: rtl/seq_next_match.sv
// rtl/seq_next_match.sv - combinational next match length (longest pattern prefix ending at the new bit)
module seq_next_match
    import seq_pkg::*;
#(
    parameter int                  PAT_LEN = DEFAULT_PAT_LEN,
    parameter logic [PAT_LEN-1:0]  PATTERN = DEFAULT_PATTERN,
    parameter int                  M_W     = match_width(PAT_LEN)
) (
    input  logic [M_W-1:0] i_m,
    input  logic           i_x,
    input  logic           i_overlap_en,
    output logic [M_W-1:0] o_next_m
);
    // Matched history is always the first m pattern bits, so the candidate
    // sequence is rebuilt from PATTERN itself rather than stored.
    function automatic logic [M_W-1:0] calc_next(input int m, input logic xb);
        int   best;
        logic ok;
        best = 0;
        for (int k = 1; k <= PAT_LEN; k++) begin
            if (k <= m + 1) begin
                ok = (xb == PATTERN[PAT_LEN-k]);
                for (int i = 0; i < PAT_LEN - 1; i++) begin
                    if (i < k - 1) begin
                        if (PATTERN[PAT_LEN-1-(m+1-k+i)] != PATTERN[PAT_LEN-1-i])
                            ok = 1'b0;
                    end
                end
                if (ok)
                    best = k;
            end
        end
        return M_W'(best);
    endfunction

    logic [M_W-1:0] w_m_eff;

    always_comb begin
        w_m_eff = i_m;
        if (i_m == M_W'(PAT_LEN) && !i_overlap_en)
            w_m_eff = '0;
    end

    always_comb begin
        o_next_m = '0;
        for (int mm = 0; mm <= PAT_LEN; mm++) begin
            if (w_m_eff == M_W'(mm))
                o_next_m = calc_next(mm, i_x);
        end
    end
endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - serial pattern detector: match-length register, Moore flag, saturating hit counter
module seq_detect_param
    import seq_pkg::*;
#(
    parameter int                 PAT_LEN = DEFAULT_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEFAULT_PATTERN,
    parameter int                 CNT_W   = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             x_valid,
    input  logic             overlap_en,
    input  logic             clear_cnt,
    output logic             z,
    output logic [CNT_W-1:0] det_count,
    output logic             det_sat
);
    localparam int               M_W     = match_width(PAT_LEN);
    localparam logic [M_W-1:0]   M_FULL  = M_W'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    generate
        if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX ||
            CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_param
            $error("seq_detect_param: PAT_LEN or CNT_W out of range");
        end
    endgenerate

    logic [M_W-1:0]   r_m;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic [M_W-1:0]   w_next_m;
    logic             w_hit;

    seq_next_match #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN),
        .M_W     (M_W)
    ) u_next (
        .i_m          (r_m),
        .i_x          (x),
        .i_overlap_en (overlap_en),
        .o_next_m     (w_next_m)
    );

    assign w_hit = x_valid && (w_next_m == M_FULL);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m   <= '0;
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else begin
            if (x_valid)
                r_m <= w_next_m;
            // A clear wins over a detection landing on the same edge.
            if (clear_cnt) begin
                r_cnt <= '0;
                r_sat <= 1'b0;
            end else if (w_hit && r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (r_cnt == CNT_MAX - CNT_W'(1))
                    r_sat <= 1'b1;
            end
        end
    end

    assign z         = (r_m == M_FULL);
    assign det_count = r_cnt;
    assign det_sat   = r_sat;
endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 The block SHALL have parameter PAT_LEN, default 4, meaning pattern length in bits (legal range 2..16).
REQ-002 The block SHALL have parameter PATTERN, default 4'b1100, PAT_LEN bits wide, meaning the target pattern; bit PAT_LEN-1 is received first.
REQ-003 The block SHALL have parameter CNT_W, default 8, meaning the width of the detection counter (legal range 2..16).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 The block SHALL have port x, input, 1 bit: serial data bit.
REQ-007 The block SHALL have port x_valid, input, 1 bit: x is consumed only on edges where x_valid=1.
REQ-008 The block SHALL have port overlap_en, input, 1 bit: 1 selects overlapping detection, 0 selects non-overlapping.
REQ-009 The block SHALL have port clear_cnt, input, 1 bit: synchronous clear of det_count and det_sat.
REQ-010 The block SHALL have port z, output, 1 bit: Moore detect flag.
REQ-011 The block SHALL have port det_count, output, CNT_W bits: saturating count of detections.
REQ-012 The block SHALL have port det_sat, output, 1 bit: sticky flag, det_count has reached all-ones.

Function
REQ-013 The state SHALL be the match length m, range 0..PAT_LEN: the number of leading PATTERN bits currently matched.
REQ-014 For m<PAT_LEN and a valid bit x, next m SHALL be the length of the longest PATTERN prefix that is a suffix of (matched prefix followed by x); 0 if none.
REQ-015 For m=PAT_LEN with overlap_en=1, next m SHALL be computed as in REQ-014, with the full pattern as the matched prefix.
REQ-016 For m=PAT_LEN with overlap_en=0, next m SHALL be computed as from m=0 with bit x.
REQ-017 overlap_en SHALL be sampled on each valid edge; a change takes effect on the next valid bit.
REQ-018 With x_valid=0, m, z and det_count SHALL hold, except for the effect of clear_cnt.
REQ-019 z SHALL equal (m==PAT_LEN), decoded from the registered state only: no combinational path from x, x_valid or overlap_en.
REQ-020 z SHALL rise in the cycle after the edge that captures the final pattern bit, and stay high until the next valid bit or reset.
REQ-021 det_count SHALL increment by 1 on each edge where next m==PAT_LEN and x_valid=1.
REQ-022 det_count SHALL saturate at 2^CNT_W-1 with no wrap-around; det_sat SHALL be set on the same edge det_count reaches all-ones and stay set.
REQ-023 When clear_cnt=1, det_count and det_sat SHALL become 0, an increment on that same edge SHALL be discarded, and m SHALL be unaffected.

Reset
REQ-024 When reset=1 at an edge, m, z, det_count and det_sat SHALL become 0; reset SHALL take priority over all other inputs.
REQ-025 Reset mid-match SHALL discard all partial-match history.

Structure
REQ-026 A shared package seq_pkg SHALL hold the PAT_LEN and CNT_W legal-range limits and the default PATTERN constant.
REQ-027 The next-match function SHALL be a combinational sub-module seq_next_match (inputs m, x, overlap_en; output next m), parametrised by PAT_LEN and PATTERN.
REQ-028 The top level SHALL contain only the state register, the z decode and the counter.

Verification
REQ-029 Reset: apply reset for 2 cycles -> z=0, det_count=0, det_sat=0.
REQ-030 Default pattern 1100: valid bits 1,1,0,0 -> z=1 in the cycle after the 4th bit; det_count=1; next bit 1 -> z=0 and m=1.
REQ-031 PATTERN=4'b1010: bits 1,0,1,0,1,0 -> det_count=2 with overlap_en=1; det_count=1 with overlap_en=0.
REQ-032 Valid gaps (pattern 1100): 1,(gap),1,0,(gap x3),0 -> exactly one detection; z holds high through trailing idle cycles.
REQ-033 Saturation: CNT_W=2, 5 detections -> det_count=3, det_sat=1; then clear_cnt -> both 0 with z unaffected.
REQ-034 Reset mid-match (pattern 1100): bits 1,1,0, then reset, then bit 0 -> z stays 0 and det_count=0.
